// File: rtl/alu16_sched.sv
// ---------------------------------------------------------------------------
// alu16_sched
//
// Shares one combinational alu16 between two requesters.  Requests are
// arbitrated round-robin, the winning operation is latched and held on the
// ALU for a fixed number of cycles (longer for MUL/DIV/MOD), and the result
// plus flags are captured and presented as a response to the owner.  Each
// requester owns a private 6-bit flags register, so carry-in and compare
// state never cross between requesters.
//
// Ports:
//   clk, rst_n           clock, synchronous active-low reset
//   req_valid/req_ready  per-requester request handshake (2 bits each)
//   req_func0/1          ALU function code per requester (0..17 legal)
//   req_a0/b0, a1/b1     operands per requester
//   rsp_valid/rsp_ready  per-requester response handshake
//   rsp_y, rsp_flags     result and owner's updated flags (shared bus)
//   rsp_err              illegal func, or divide/modulo by zero
//   alu_a/b/func/flagsin operands driven to the shared ALU
//   alu_y, alu_flagsout  result coming back from the shared ALU
// ---------------------------------------------------------------------------
module alu16_sched #(
    parameter int MULDIV_CYCLES = 3,
    parameter int BASE_CYCLES   = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [1:0]  req_valid,
    output logic [1:0]  req_ready,
    input  logic [4:0]  req_func0,
    input  logic [4:0]  req_func1,
    input  logic [15:0] req_a0,
    input  logic [15:0] req_b0,
    input  logic [15:0] req_a1,
    input  logic [15:0] req_b1,
    output logic [1:0]  rsp_valid,
    input  logic [1:0]  rsp_ready,
    output logic [15:0] rsp_y,
    output logic [5:0]  rsp_flags,
    output logic        rsp_err,
    output logic [15:0] alu_a,
    output logic [15:0] alu_b,
    output logic [4:0]  alu_func,
    output logic [5:0]  alu_flagsin,
    input  logic [15:0] alu_y,
    input  logic [5:0]  alu_flagsout
);

    localparam logic [4:0] FUNC_MUL = 5'd2;
    localparam logic [4:0] FUNC_DIV = 5'd3;
    localparam logic [4:0] FUNC_MOD = 5'd4;
    localparam logic [4:0] FUNC_NOP = 5'd16;
    localparam logic [4:0] FUNC_MAX = 5'd17;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t      state_q;
    logic        last_q;
    logic        owner_q;
    logic [4:0]  func_q;
    logic [15:0] a_q;
    logic [15:0] b_q;
    logic [3:0]  cnt_q;
    logic [5:0]  flags_q [2];
    logic [15:0] y_q;
    logic [5:0]  rflags_q;
    logic        err_q;

    // Arbitration and selection of the candidate request.
    logic        any_req_d;
    logic        grant_d;
    logic [4:0]  sel_func_d;
    logic [15:0] sel_a_d;
    logic [15:0] sel_b_d;
    logic        is_muldiv_d;
    logic        illegal_d;
    logic        divzero_d;
    logic [3:0]  cnt_load_d;
    logic        exec_d;
    logic        resp_d;

    always_comb begin
        any_req_d = |req_valid;
        // On a tie the requester that did not win last time gets the slot;
        // with a single request that one wins regardless of history.
        if (req_valid == 2'b11) begin
            grant_d = ~last_q;
        end else begin
            grant_d = req_valid[1];
        end
        sel_func_d  = grant_d ? req_func1 : req_func0;
        sel_a_d     = grant_d ? req_a1    : req_a0;
        sel_b_d     = grant_d ? req_b1    : req_b0;
        is_muldiv_d = (sel_func_d == FUNC_MUL) || (sel_func_d == FUNC_DIV) ||
                      (sel_func_d == FUNC_MOD);
        illegal_d   = sel_func_d > FUNC_MAX;
        divzero_d   = ((sel_func_d == FUNC_DIV) || (sel_func_d == FUNC_MOD)) &&
                      (sel_b_d == 16'd0);
        cnt_load_d  = is_muldiv_d ? 4'(MULDIV_CYCLES - 1) : 4'(BASE_CYCLES - 1);
        exec_d      = rst_n && (state_q == EXEC);
        resp_d      = rst_n && (state_q == RESP);
    end

    // Every output is forced to its idle value while reset is asserted so
    // nothing leaks out during the cycle in which reset is first sampled.
    always_comb begin
        req_ready = 2'b00;
        if (rst_n && (state_q == IDLE) && any_req_d) begin
            req_ready = grant_d ? 2'b10 : 2'b01;
        end
        rsp_valid = 2'b00;
        if (resp_d) begin
            rsp_valid = owner_q ? 2'b10 : 2'b01;
        end
        rsp_y       = rst_n ? y_q      : 16'd0;
        rsp_flags   = rst_n ? rflags_q : 6'd0;
        rsp_err     = rst_n & err_q;
        alu_a       = exec_d ? a_q              : 16'd0;
        alu_b       = exec_d ? b_q              : 16'd0;
        alu_func    = exec_d ? func_q           : FUNC_NOP;
        alu_flagsin = exec_d ? flags_q[owner_q] : 6'd0;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            last_q     <= 1'b1;
            owner_q    <= 1'b0;
            func_q     <= 5'd0;
            a_q        <= 16'd0;
            b_q        <= 16'd0;
            cnt_q      <= 4'd0;
            y_q        <= 16'd0;
            rflags_q   <= 6'd0;
            err_q      <= 1'b0;
            flags_q[0] <= 6'd0;
            flags_q[1] <= 6'd0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (any_req_d) begin
                        owner_q <= grant_d;
                        last_q  <= grant_d;
                        func_q  <= sel_func_d;
                        a_q     <= sel_a_d;
                        b_q     <= sel_b_d;
                        cnt_q   <= cnt_load_d;
                        if (illegal_d || divzero_d) begin
                            // Rejected without touching the ALU; the
                            // requester's flags are reported unchanged.
                            y_q      <= illegal_d ? 16'd0 : 16'hFFFF;
                            err_q    <= 1'b1;
                            rflags_q <= flags_q[grant_d];
                            state_q  <= RESP;
                        end else begin
                            err_q   <= 1'b0;
                            state_q <= EXEC;
                        end
                    end
                end
                EXEC: begin
                    if (cnt_q == 4'd0) begin
                        y_q   <= alu_y;
                        err_q <= 1'b0;
                        // NOP must not disturb the owner's carry/compare state.
                        if (func_q != FUNC_NOP) begin
                            flags_q[owner_q] <= alu_flagsout;
                            rflags_q         <= alu_flagsout;
                        end else begin
                            rflags_q <= flags_q[owner_q];
                        end
                        state_q <= RESP;
                    end else begin
                        cnt_q <= cnt_q - 4'd1;
                    end
                end
                RESP: begin
                    if (rsp_ready[owner_q]) begin
                        state_q <= IDLE;
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_alu16_sched.sv
// ---------------------------------------------------------------------------
// tb_alu16_sched
//
// Bench for alu16_sched with default timing (MUL/DIV/MOD 3 cycles, others 1).
// A stand-in combinational ALU answers the scheduler.  The reference model
// tracks per-requester flags, the round-robin history and the busy/idle
// protocol at the transaction level; expected responses are queued at
// accept and checked by a monitor when the response handshake happens.
// ---------------------------------------------------------------------------
module tb_alu16_sched;

    localparam int MULDIV_N = 3;
    localparam int BASE_N   = 1;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [1:0]  req_valid;
    logic [1:0]  req_ready;
    logic [4:0]  req_func0, req_func1;
    logic [15:0] req_a0, req_b0, req_a1, req_b1;
    logic [1:0]  rsp_valid;
    logic [1:0]  rsp_ready;
    logic [15:0] rsp_y;
    logic [5:0]  rsp_flags;
    logic        rsp_err;
    logic [15:0] alu_a, alu_b;
    logic [4:0]  alu_func;
    logic [5:0]  alu_flagsin;
    logic [15:0] alu_y;
    logic [5:0]  alu_flagsout;

    always #5 clk = ~clk;

    alu16_sched #(
        .MULDIV_CYCLES(MULDIV_N),
        .BASE_CYCLES  (BASE_N)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_func0   (req_func0),
        .req_func1   (req_func1),
        .req_a0      (req_a0),
        .req_b0      (req_b0),
        .req_a1      (req_a1),
        .req_b1      (req_b1),
        .rsp_valid   (rsp_valid),
        .rsp_ready   (rsp_ready),
        .rsp_y       (rsp_y),
        .rsp_flags   (rsp_flags),
        .rsp_err     (rsp_err),
        .alu_a       (alu_a),
        .alu_b       (alu_b),
        .alu_func    (alu_func),
        .alu_flagsin (alu_flagsin),
        .alu_y       (alu_y),
        .alu_flagsout(alu_flagsout)
    );

    // Stand-in ALU.  Flag bits: [0] less-than, [1] zero, [2] sign,
    // [3] carry (also the carry-in), [4] carry-out/overflow.
    // NOP deliberately returns inverted flags so a scheduler that writes
    // them back is caught.
    function automatic logic [21:0] alu_fn(input logic [4:0] f, input logic [15:0] a,
                                           input logic [15:0] b, input logic [5:0] fin);
        logic [16:0] s;
        logic [31:0] p;
        logic [15:0] y;
        logic [5:0]  fl;
        s  = 17'd0;
        p  = 32'd0;
        y  = 16'd0;
        fl = 6'd0;
        case (f)
            5'd0: begin
                s = {1'b0, a} + {1'b0, b} + {16'd0, fin[3]};
                y = s[15:0]; fl[4] = s[16]; fl[3] = s[16]; fl[2] = y[15]; fl[1] = (y == 16'd0);
            end
            5'd1: begin
                s = {1'b0, a} - {1'b0, b};
                y = s[15:0]; fl[3] = s[16]; fl[1] = (y == 16'd0);
            end
            5'd2: begin
                p = 32'(a) * 32'(b);
                y = p[15:0]; fl[4] = |p[31:16]; fl[1] = (y == 16'd0);
            end
            5'd3: begin
                y = (b == 16'd0) ? 16'hFFFF : a / b; fl[1] = (y == 16'd0);
            end
            5'd4: begin
                y = (b == 16'd0) ? a : a % b; fl[1] = (y == 16'd0);
            end
            5'd5: begin
                fl[0] = (a < b); fl[1] = (a == b);
            end
            5'd16: begin
                fl = ~fin;
            end
            default: begin
                y  = a ^ {b[7:0], b[15:8]} ^ {11'd0, f};
                fl = a[5:0] ^ {1'b0, f};
            end
        endcase
        return {fl, y};
    endfunction

    always_comb {alu_flagsout, alu_y} = alu_fn(alu_func, alu_a, alu_b, alu_flagsin);

    typedef struct packed {
        logic        owner;
        logic [4:0]  f;
        logic [15:0] a;
        logic [15:0] b;
        logic [5:0]  fin;
        logic [15:0] y;
        logic [5:0]  fl;
        logic        err;
        logic [7:0]  lat;
    } exp_t;

    exp_t        sbq[$];
    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;
    int          acc_cyc = 0;
    int          rst_edges = 0;
    int          n_rsp = 0;
    logic        busy = 1'b0;
    logic        seen = 1'b0;
    logic        m_last = 1'b1;
    logic [5:0]  m_flags [2];
    logic [1:0]  acc_flag = 2'b00;

    // Monitor scratch
    logic [1:0]  exp_ready;
    logic        m_g;
    logic [21:0] m_r;
    exp_t        m_e;

    task automatic chk(input string name, input logic ok, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
        end
    endtask

    always @(posedge clk) begin
        if (!rst_n) rst_edges++;
        else        rst_edges = 0;
    end

    // Monitor / scoreboard: samples on the falling edge.
    always @(negedge clk) begin
        cyc++;
        if (!rst_n) begin
            if (rst_edges > 0) begin
                chk("rst_req_ready", req_ready == 2'b00, 32'(req_ready), 32'd0);
                chk("rst_rsp", {rsp_valid, rsp_y, rsp_flags, rsp_err} == 25'd0,
                    32'({rsp_valid, rsp_y, rsp_flags, rsp_err}), 32'd0);
                chk("rst_alu", {alu_a, alu_b, alu_func, alu_flagsin} == {32'd0, 5'd16, 6'd0},
                    32'({alu_func, alu_flagsin}), 32'({5'd16, 6'd0}));
            end
            sbq.delete();
            busy       = 1'b0;
            seen       = 1'b0;
            m_last     = 1'b1;
            m_flags[0] = 6'd0;
            m_flags[1] = 6'd0;
            acc_flag   = 2'b00;
        end else begin
            exp_ready = 2'b00;
            if (!busy && req_valid != 2'b00) begin
                if (req_valid == 2'b11) exp_ready = m_last ? 2'b01 : 2'b10;
                else                    exp_ready = req_valid;
            end
            chk("req_ready", req_ready == exp_ready, 32'(req_ready), 32'(exp_ready));
            if (!busy) chk("no_rsp_when_idle", rsp_valid == 2'b00, 32'(rsp_valid), 32'd0);
            if (!busy || rsp_valid != 2'b00)
                chk("alu_idle", {alu_a, alu_b, alu_func, alu_flagsin} == {32'd0, 5'd16, 6'd0},
                    32'({alu_func, alu_flagsin, alu_a[7:0]}), 32'({5'd16, 6'd0, 8'd0}));

            if ((req_valid & req_ready) != 2'b00) begin
                m_g       = req_ready[1];
                m_e       = '0;
                m_e.owner = m_g;
                m_e.f     = m_g ? req_func1 : req_func0;
                m_e.a     = m_g ? req_a1 : req_a0;
                m_e.b     = m_g ? req_b1 : req_b0;
                m_e.fin   = m_flags[m_g];
                if (m_e.f > 5'd17) begin
                    m_e.y = 16'd0; m_e.fl = m_flags[m_g]; m_e.err = 1'b1;
                end else if ((m_e.f == 5'd3 || m_e.f == 5'd4) && m_e.b == 16'd0) begin
                    m_e.y = 16'hFFFF; m_e.fl = m_flags[m_g]; m_e.err = 1'b1;
                end else begin
                    m_r   = alu_fn(m_e.f, m_e.a, m_e.b, m_flags[m_g]);
                    m_e.y = m_r[15:0];
                    m_e.fl = (m_e.f == 5'd16) ? m_flags[m_g] : m_r[21:16];
                    m_flags[m_g] = m_e.fl;
                end
                // Counted in falling edges from the one where the handshake
                // is seen: errors answer on the next, ALU ops after N held
                // cycles plus the capture edge.
                if (m_e.err)
                    m_e.lat = 8'd1;
                else if (m_e.f >= 5'd2 && m_e.f <= 5'd4)
                    m_e.lat = 8'(MULDIV_N + 1);
                else
                    m_e.lat = 8'(BASE_N + 1);
                sbq.push_back(m_e);
                m_last  = m_g;
                busy    = 1'b1;
                seen    = 1'b0;
                acc_cyc = cyc;
                acc_flag[m_g] = 1'b1;
            end else if (busy && sbq.size() > 0) begin
                m_e = sbq[0];
                if (rsp_valid == 2'b00) begin
                    if (!m_e.err)
                        chk("alu_hold", {alu_func, alu_a, alu_b, alu_flagsin} ==
                                        {m_e.f, m_e.a, m_e.b, m_e.fin},
                            32'({alu_func, alu_flagsin, alu_a[7:0], alu_b[7:0]}),
                            32'({m_e.f, m_e.fin, m_e.a[7:0], m_e.b[7:0]}));
                    if (cyc - acc_cyc > 100) begin
                        checks++;
                        errors++;
                        $display("FAIL rsp_timeout actual=%0d cycles required<=100", cyc - acc_cyc);
                        sbq.delete();
                        busy = 1'b0;
                    end
                end else begin
                    if (!seen) begin
                        seen = 1'b1;
                        chk("latency", (cyc - acc_cyc) == int'(m_e.lat), 32'(cyc - acc_cyc),
                            32'(m_e.lat));
                    end
                    chk("rsp_valid_bit", rsp_valid == (m_e.owner ? 2'b10 : 2'b01),
                        32'(rsp_valid), 32'(m_e.owner ? 2'b10 : 2'b01));
                    if ((rsp_valid & rsp_ready) != 2'b00) begin
                        chk("rsp_y", rsp_y == m_e.y, 32'(rsp_y), 32'(m_e.y));
                        chk("rsp_flags", rsp_flags == m_e.fl, 32'(rsp_flags), 32'(m_e.fl));
                        chk("rsp_err", rsp_err == m_e.err, 32'(rsp_err), 32'(m_e.err));
                        $display("rsp req=%0d func=%0d a=%h b=%h y=%h flags=%b err=%0d",
                                 m_e.owner, m_e.f, m_e.a, m_e.b, rsp_y, rsp_flags, rsp_err);
                        n_rsp++;
                        void'(sbq.pop_front());
                        busy = 1'b0;
                    end
                end
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic set_ops(input int i, input logic [4:0] f, input logic [15:0] a,
                           input logic [15:0] b);
        if (i == 0) begin
            req_func0 = f; req_a0 = a; req_b0 = b;
        end else begin
            req_func1 = f; req_a1 = a; req_b1 = b;
        end
    endtask

    task automatic set_req(input int i, input logic [4:0] f, input logic [15:0] a,
                           input logic [15:0] b);
        set_ops(i, f, a, b);
        req_valid[i] = 1'b1;
    endtask

    task automatic rand_req(input int i);
        int          r;
        logic [4:0]  f;
        logic [15:0] b;
        r = int'($urandom_range(0, 9));
        if (r < 7)      f = 5'($urandom_range(0, 5));
        else if (r < 9) f = 5'($urandom_range(6, 17));
        else            f = 5'($urandom_range(18, 31));
        b = ($urandom_range(0, 7) == 0) ? 16'd0 : 16'($urandom);
        set_req(i, f, 16'($urandom), b);
    endtask

    // Advance one cycle; drop (and scramble) any request accepted on that edge.
    task automatic step();
        @(posedge clk);
        #1;
        for (int i = 0; i < 2; i++) begin
            if (acc_flag[i]) begin
                acc_flag[i]  = 1'b0;
                req_valid[i] = 1'b0;
                set_ops(i, 5'($urandom), 16'($urandom), 16'($urandom));
            end
        end
    endtask

    task automatic wait_idle(input int max_cyc);
        int n;
        n = 0;
        do begin
            step();
            n++;
        end while ((req_valid != 2'b00 || busy || sbq.size() != 0) && n < max_cyc);
        chk("drain", n < max_cyc, 32'(n), 32'(max_cyc));
    endtask

    initial begin
        rst_n     = 1'b0;
        req_valid = 2'b00;
        rsp_ready = 2'b11;
        set_ops(0, 5'd0, 16'd0, 16'd0);
        set_ops(1, 5'd0, 16'd0, 16'd0);
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Directed: carry chain on requester 0, MUL, error cases, CMP/NOP on 1.
        set_req(0, 5'd0, 16'hFFFF, 16'd1);  wait_idle(50);
        set_req(0, 5'd0, 16'd1, 16'd1);     wait_idle(50);
        set_req(0, 5'd2, 16'd300, 16'd300); wait_idle(50);
        set_req(0, 5'd3, 16'd10, 16'd0);    wait_idle(50);
        set_req(0, 5'd20, 16'd1, 16'd2);    wait_idle(50);
        set_req(1, 5'd5, 16'd5, 16'd9);     wait_idle(50);
        set_req(1, 5'd16, 16'd0, 16'd0);    wait_idle(50);
        set_req(0, 5'd4, 16'd17, 16'd5);    wait_idle(50);

        // Both requesting together: grants must alternate.
        for (int k = 0; k < 4; k++) begin
            rand_req(0);
            rand_req(1);
            wait_idle(100);
        end

        // Random traffic with random response back-pressure.
        for (int k = 0; k < 400; k++) begin
            step();
            for (int i = 0; i < 2; i++)
                if (!req_valid[i] && $urandom_range(0, 2) == 0) rand_req(i);
            rsp_ready = 2'($urandom_range(0, 3));
        end
        rsp_ready = 2'b11;
        wait_idle(200);

        // Reset in the middle of a DIV; requester 1 waits through reset.
        set_req(0, 5'd3, 16'd100, 16'd7);
        for (int k = 0; k < 20 && req_valid[0]; k++) step();
        step();
        rst_n = 1'b0;
        set_req(1, 5'd0, 16'd2, 16'd3);
        step();
        step();
        rst_n = 1'b1;
        wait_idle(50);
        set_req(0, 5'd1, 16'd9, 16'd4);
        wait_idle(50);

        chk("rsp_count_nonzero", n_rsp > 20, 32'(n_rsp), 32'd21);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/alu16_sched.md
# alu16_sched

Scheduler that shares one `alu16` instance between two requesters (e.g. the execute stage and a DMA/address-generation unit). It arbitrates round-robin and latches the winning operation's operands. It holds them stable on the ALU for a fixed number of cycles (more for MUL/DIV/MOD), then captures result and flags. It keeps a private 6-bit flags register per requester, so carry-in and compare state never leak between requesters.

## Interface
Parameters:
- `MULDIV_CYCLES`, default 3: cycles the ALU inputs are held for func 2/3/4; legal range 1..15.
- `BASE_CYCLES`, default 1: cycles held for every other func; legal range 1..15.

Ports:
- `clk` in 1: single clock; everything is rising-edge.
- `rst_n` in 1: synchronous, active-low reset.
- `req_valid` in 2: per-requester request valid.
- `req_ready` out 2: per-requester accept.
- `req_func0`, `req_func1` in 5: ALU function codes (0..17).
- `req_a0`, `req_b0`, `req_a1`, `req_b1` in 16: operands.
- `rsp_valid` out 2: per-requester response valid.
- `rsp_ready` in 2: per-requester response accept.
- `rsp_y` out 16: result (shared bus; qualified by `rsp_valid`).
- `rsp_flags` out 6: updated flags of the responding requester.
- `rsp_err` out 1: illegal func, or divide/modulo by zero.
- `alu_a`, `alu_b` out 16: ALU operands.
- `alu_func` out 5: ALU function.
- `alu_flagsin` out 6: ALU flag input.
- `alu_y` in 16: ALU result.
- `alu_flagsout` in 6: ALU flag output.

## Operation
- States: IDLE, EXEC, RESP.
- IDLE:
  - `req_ready[i]` = 1 only for the granted requester `g`; the other bit is 0.
  - Grant rule: if exactly one `req_valid` bit is set, grant it. If both are set, grant `~last`.
  - `last` resets to 1, so requester 0 wins the first tie.
- Handshake (`req_valid[g] & req_ready[g]`):
  - Latch func, a, b and the owner `g`; set `last <= g`.
  - Load cycle counter with `MULDIV_CYCLES-1` (func 2/3/4) or `BASE_CYCLES-1` (others); go to EXEC.
- Pre-checked errors at accept go straight to RESP with `rsp_err`=1 and the requester's flags unchanged; EXEC is skipped:
  - func > 17: `rsp_y`=0.
  - func 3/4 with b==0: `rsp_y`=16'hFFFF.
- EXEC:
  - `alu_a`/`alu_b`/`alu_func` come from the latched registers.
  - `alu_flagsin` = the owner's flags register.
  - Counter decrements each cycle. On the edge where it is 0, capture `alu_y` into the result register and write flags, then go to RESP.
- Flags writeback:
  - The owner's flags register <= `alu_flagsout` for all funcs except 16 (NOP), which keeps the old value.
  - The other requester's flags are never touched.
- RESP:
  - `rsp_valid[owner]`=1; `rsp_y`, `rsp_flags` (owner's new flags) and `rsp_err` are held stable.
  - On `rsp_ready[owner]`, return to IDLE.
  - `rsp_valid[~owner]`=0 always.
- Outside EXEC: `alu_a`=`alu_b`=0, `alu_func`=16 (NOP), `alu_flagsin`=0.

## Timing
- Reset values: state IDLE, both flags registers 0, `last`=1, counter 0.
- Outputs under reset: `req_ready`=0, `rsp_valid`=0, `rsp_y`=0, `rsp_flags`=0, `rsp_err`=0, ALU outputs as idle above.
- `req_ready` is combinational from state and `req_valid`. It may be low while `req_valid` is high; requesters must hold the request stable until accepted.
- Latency, accept edge to first `rsp_valid` cycle: N = `BASE_CYCLES` or `MULDIV_CYCLES`; error case is 1 cycle.
- With `rsp_ready` tied high, throughput is one op per N+2 cycles. There is no accept in the cycle the response is consumed; IDLE is always visited.
- Simultaneous `req_valid` while busy: ignored until IDLE, then arbitrated by `last`. A requester cannot win twice in a row while the other is waiting.
- `rsp_ready` high outside RESP: ignored.
- Changing `req_*` after accept: no effect; operands are latched.
- `rst_n` low in any state: on the next edge return to reset values and drop any in-flight op without a response. Flags registers clear.
- ALU is purely combinational; the capture edge samples its settled output after N held cycles.

## Test plan
- Requester 0, ADD a=16'hFFFF b=1 with flags 0 -> `rsp_y`=0, `rsp_flags[4]`=1 one cycle after accept. Next ADD a=1 b=1 -> `rsp_y`=3, using the carry captured into `flags[3]` by the ALU.
- Both valid at the same edge, repeatedly, `rsp_ready`=1 -> grants alternate 0,1,0,1 starting with 0 after reset. Each response appears only on its own `rsp_valid` bit.
- MUL 300×300 with `MULDIV_CYCLES`=3 -> `rsp_valid` exactly 3 cycles after accept, `rsp_y`=16'h5F90, `flags[4]`=1.
- DIV a=10 b=0 -> `rsp_err`=1, `rsp_y`=16'hFFFF next cycle, flags unchanged. func=20 -> `rsp_err`=1, `rsp_y`=0.
- CMP a=5 b=9 on requester 1, then NOP -> first response `rsp_flags`=6'b000001 (LF), NOP response keeps 6'b000001. Requester 0 flags remain 0.
- `rst_n` pulsed low during EXEC of a DIV -> no response; all outputs at reset values. A new request is accepted from the first cycle after reset deasserts.
